// File: rtl/t_ff_sched_pkg.sv
// Shared types for the t_ff toggle scheduler: FSM states, per-channel config record
// and the period-to-reload helper.
package t_ff_sched_pkg;

  localparam int SCHED_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_t;

  typedef struct packed {
    logic                   en;
    logic [SCHED_CNT_W-1:0] period;
    logic [SCHED_CNT_W-1:0] count;
  } chan_cfg_t;

  // A period of 0 behaves like 1, so both reload the down-counter with 0.
  function automatic logic [SCHED_CNT_W-1:0] reload_val(input logic [SCHED_CNT_W-1:0] period);
    return (period == '0) ? '0 : period - SCHED_CNT_W'(1);
  endfunction

endpackage

// File: rtl/t_ff_toggle_sched_if.sv
// Valid/ready configuration port of the t_ff toggle scheduler.
interface t_ff_toggle_sched_if #(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
);
  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic             cfg_en;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_count;

  modport master (
    output cfg_valid, cfg_ch, cfg_en, cfg_period, cfg_count,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_ch, cfg_en, cfg_period, cfg_count,
    output cfg_ready
  );

endinterface

// File: rtl/t_ff_sched_chan.sv
// One scheduler channel: config shadow, period down-counter and remaining-toggle counter.
module t_ff_sched_chan
  import t_ff_sched_pkg::*;
#(
  parameter int CNT_W = SCHED_CNT_W
) (
  input  logic      clk,
  input  logic      rstn,
  input  logic      cfg_wr,
  input  chan_cfg_t cfg_new,
  input  logic      launch,
  input  logic      abort,
  output logic      en,
  output logic      t,
  output logic      busy,
  output logic      fin
);

  chan_cfg_t        shadow;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] left;
  logic             finite;
  logic             spent;
  logic             fire;

  assign en     = shadow.en;
  assign finite = (shadow.count != '0);
  assign spent  = finite && (left == '0);
  assign fire   = busy && (cnt == '0) && !spent;
  // fin is high once nothing more will be issued: idle, or the last strobe is out.
  assign fin    = !busy || spent;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      shadow <= '0;
      cnt    <= '0;
      left   <= '0;
      t      <= 1'b0;
      busy   <= 1'b0;
    end else begin
      if (cfg_wr) shadow <= cfg_new;
      if (abort) begin
        t    <= 1'b0;
        busy <= 1'b0;
      end else if (launch) begin
        t    <= 1'b0;
        busy <= shadow.en;
        cnt  <= CNT_W'(reload_val(shadow.period));
        left <= CNT_W'(shadow.count);
      end else if (busy) begin
        t   <= fire;
        cnt <= (cnt == '0) ? CNT_W'(reload_val(shadow.period)) : cnt - CNT_W'(1);
        if (fire && finite) left <= left - CNT_W'(1);
        // Drop busy on the edge that ends the final strobe.
        if (t && spent) busy <= 1'b0;
      end else begin
        t <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/t_ff_toggle_sched.sv
// Top of the t_ff toggle scheduler: sequencing FSM, config decode, done pulse
// and the cross-channel reductions.
//   state | meaning
//   IDLE  | config writes accepted, waiting for start
//   RUN   | channels scheduling toggles until all finite ones finish or stop
//   DONE  | one-cycle done pulse, then back to IDLE
module t_ff_toggle_sched
  import t_ff_sched_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = SCHED_CNT_W
) (
  input  logic                clk,
  input  logic                rstn,
  t_ff_toggle_sched_if.slave  cfg,
  input  logic                start,
  input  logic                stop,
  output logic [N_CH-1:0]     t,
  output logic [N_CH-1:0]     busy,
  output logic                done
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;

  sched_state_t    state;
  logic [N_CH-1:0] en_vec;
  logic [N_CH-1:0] fin_vec;
  logic [N_CH-1:0] wr_vec;
  logic            launch;
  logic            abort;
  chan_cfg_t       cfg_new;

  assign cfg_new = '{en:     cfg.cfg_en,
                     period: SCHED_CNT_W'(cfg.cfg_period),
                     count:  SCHED_CNT_W'(cfg.cfg_count)};

  assign launch = (state == IDLE) && start && !stop && (|en_vec);
  assign abort  = (state == RUN) && stop;

  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    assign wr_vec[i] = cfg.cfg_valid && cfg.cfg_ready && (cfg.cfg_ch == CH_W'(i));

    t_ff_sched_chan #(.CNT_W(CNT_W)) u_chan (
      .clk     (clk),
      .rstn    (rstn),
      .cfg_wr  (wr_vec[i]),
      .cfg_new (cfg_new),
      .launch  (launch),
      .abort   (abort),
      .en      (en_vec[i]),
      .t       (t[i]),
      .busy    (busy[i]),
      .fin     (fin_vec[i])
    );
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      done          <= 1'b0;
      cfg.cfg_ready <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (launch) begin
            state         <= RUN;
            cfg.cfg_ready <= 1'b0;
          end
        end
        RUN: begin
          if (stop) begin
            state         <= IDLE;
            cfg.cfg_ready <= 1'b1;
          end else if (&fin_vec) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state         <= IDLE;
          done          <= 1'b0;
          cfg.cfg_ready <= 1'b1;
        end
        default: begin
          state         <= IDLE;
          done          <= 1'b0;
          cfg.cfg_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_t_ff_toggle_sched.sv
// Directed bench for t_ff_toggle_sched driving a local bank of four toggle flops.
module tb_t_ff_toggle_sched;

  logic       clk;
  logic       rstn;
  logic       start;
  logic       stop;
  logic [3:0] t;
  logic [3:0] busy;
  logic       done;
  logic [3:0] q;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] t_hist [4];
  logic [31:0] busy_hist [4];
  logic [31:0] q_hist [4];
  logic [31:0] done_hist;
  logic [31:0] rdy_hist;

  t_ff_toggle_sched_if #(.N_CH(4), .CNT_W(8)) cfg_if ();

  t_ff_toggle_sched #(.N_CH(4), .CNT_W(8)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .cfg   (cfg_if),
    .start (start),
    .stop  (stop),
    .t     (t),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Bank of t_ff: q flips on every rising edge where t is high.
  always @(posedge clk or negedge rstn) begin
    if (!rstn) q <= '0;
    else       q <= q ^ t;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [1:0] ch, input logic en, input logic [7:0] period,
                           input logic [7:0] count);
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = ch;
    cfg_if.cfg_en     = en;
    cfg_if.cfg_period = period;
    cfg_if.cfg_count  = count;
    @(negedge clk);
    cfg_if.cfg_valid  = 1'b0;
  endtask

  // Pulses start for one edge (edge k); returns at the falling edge after edge k.
  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Records outputs after edges k+1..k+n into bit n of the history vectors.
  task automatic capture(input int n);
    for (int c = 0; c < 4; c++) begin
      t_hist[c]    = '0;
      busy_hist[c] = '0;
      q_hist[c]    = '0;
    end
    done_hist = '0;
    rdy_hist  = '0;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      for (int c = 0; c < 4; c++) begin
        t_hist[c][i]    = t[c];
        busy_hist[c][i] = busy[c];
        q_hist[c][i]    = q[c];
      end
      done_hist[i] = done;
      rdy_hist[i]  = cfg_if.cfg_ready;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn              = 1'b0;
    start             = 1'b0;
    stop              = 1'b0;
    cfg_if.cfg_valid  = 1'b0;
    cfg_if.cfg_ch     = '0;
    cfg_if.cfg_en     = 1'b0;
    cfg_if.cfg_period = '0;
    cfg_if.cfg_count  = '0;

    // 1. reset
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("rst_t", 32'(t), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    check("rst_ready", 32'(cfg_if.cfg_ready), 32'h1);
    check("rst_q", 32'(q), 32'h0);
    rstn = 1'b1;
    @(negedge clk);
    check("post_rst_ready", 32'(cfg_if.cfg_ready), 32'h1);

    // 2. ch0 P=3 count=4
    cfg_write(2'd0, 1'b1, 8'd3, 8'd4);
    pulse_start();
    capture(16);
    check("t2_t0", t_hist[0], 32'h1248);
    check("t2_t_other", t_hist[1] | t_hist[2] | t_hist[3], 32'h0);
    check("t2_busy0", busy_hist[0], 32'h1FFE);
    check("t2_done", done_hist, 32'h2000);
    check("t2_ready", rdy_hist, 32'h1C000);
    check("t2_q0", q_hist[0], 32'h1C70);

    // 3. ch1 continuous with P=0, then stop
    cfg_write(2'd0, 1'b0, 8'd0, 8'd0);
    cfg_write(2'd1, 1'b1, 8'd0, 8'd0);
    pulse_start();
    capture(6);
    check("t3_t1", t_hist[1], 32'h7E);
    check("t3_busy1", busy_hist[1], 32'h7E);
    check("t3_q1", q_hist[1], 32'h54);
    check("t3_ready_run", rdy_hist, 32'h0);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    check("t3_stop_t", 32'(t), 32'h0);
    check("t3_stop_busy", 32'(busy), 32'h0);
    check("t3_stop_ready", 32'(cfg_if.cfg_ready), 32'h1);
    check("t3_stop_done", 32'(done), 32'h0);
    @(negedge clk);
    check("t3_after_done", 32'(done), 32'h0);
    check("t3_after_q1", 32'(q[1]), 32'h0);

    // 4. ch2 P=2 count=3, ch3 P=5 count=1
    cfg_write(2'd1, 1'b0, 8'd0, 8'd0);
    cfg_write(2'd2, 1'b1, 8'd2, 8'd3);
    cfg_write(2'd3, 1'b1, 8'd5, 8'd1);
    pulse_start();
    capture(10);
    check("t4_t2", t_hist[2], 32'h54);
    check("t4_t3", t_hist[3], 32'h20);
    check("t4_busy2", busy_hist[2], 32'h7E);
    check("t4_busy3", busy_hist[3], 32'h3E);
    check("t4_done", done_hist, 32'h80);
    check("t4_ready", rdy_hist, 32'h700);
    check("t4_q2", q_hist[2], 32'h798);
    check("t4_q3", q_hist[3], 32'h7C0);

    // 5a. start with stop in IDLE
    @(negedge clk);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    capture(3);
    check("t5a_busy", busy_hist[2] | busy_hist[3], 32'h0);
    check("t5a_ready", rdy_hist, 32'hE);

    // 5b. start with no channel enabled
    cfg_write(2'd2, 1'b0, 8'd0, 8'd0);
    cfg_write(2'd3, 1'b0, 8'd0, 8'd0);
    pulse_start();
    capture(3);
    check("t5b_busy", busy_hist[0] | busy_hist[1] | busy_hist[2] | busy_hist[3], 32'h0);
    check("t5b_ready", rdy_hist, 32'hE);

    // 5c. config write attempted during RUN is held off
    cfg_write(2'd0, 1'b1, 8'd4, 8'd2);
    pulse_start();
    cfg_if.cfg_valid  = 1'b1;
    cfg_if.cfg_ch     = 2'd0;
    cfg_if.cfg_en     = 1'b1;
    cfg_if.cfg_period = 8'd1;
    cfg_if.cfg_count  = 8'd0;
    capture(10);
    cfg_if.cfg_valid  = 1'b0;
    check("t5c_t0", t_hist[0], 32'h110);
    check("t5c_busy0", busy_hist[0], 32'h1FE);
    check("t5c_done", done_hist, 32'h200);
    check("t5c_ready", rdy_hist, 32'h400);

    // 6. reset in the middle of RUN
    cfg_write(2'd0, 1'b1, 8'd2, 8'd10);
    pulse_start();
    capture(4);
    check("t6_pre_t0", t_hist[0], 32'h14);
    check("t6_pre_busy0", 32'(busy[0]), 32'h1);
    #2 rstn = 1'b0;
    #1;
    check("t6_async_t", 32'(t), 32'h0);
    check("t6_async_busy", 32'(busy), 32'h0);
    check("t6_async_done", 32'(done), 32'h0);
    check("t6_async_ready", 32'(cfg_if.cfg_ready), 32'h1);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    pulse_start();
    capture(8);
    check("t6_post_t", t_hist[0] | t_hist[1] | t_hist[2] | t_hist[3], 32'h0);
    check("t6_post_busy", busy_hist[0] | busy_hist[1] | busy_hist[2] | busy_hist[3], 32'h0);
    check("t6_post_ready", rdy_hist, 32'h1FE);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
